udma_eth_tx_seq: RTL and testbench
==================================

Name: udma_eth_tx_seq

Overview:
- TX frame sequencer between the uDMA TX word stream (32-bit, post clock-domain crossing) and the 8-bit Ethernet MAC AXIS TX input.
- Each frame is a header word carrying the byte length, followed by ceil(L/4) payload words.
- Serializes payload bytes little-endian and generates tlast on byte L-1.
- Validates length, supports abort with bad-frame marking, and drains aborted payload.

Parameters:
- LEN_WIDTH, 16, width of the frame length field (header bits [LEN_WIDTH-1:0]).
- MAX_FRAME_LEN, 1518, largest legal byte length.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  sequencer enable.
- clr_i  in  1  1-cycle abort pulse.
- s_data_i  in  32  word stream data.
- s_valid_i  in  1  word valid.
- s_ready_o  out  1  word accept.
- m_tdata_o  out  8  AXIS byte.
- m_tvalid_o  out  1  AXIS valid.
- m_tready_i  in  1  AXIS ready.
- m_tlast_o  out  1  last byte of frame.
- m_tuser_o  out  1  bad-frame marker, valid with tlast.
- busy_o  out  1  high in any state other than IDLE/HDR.
- frame_done_o  out  1  1-cycle pulse on a good tlast handshake.
- len_err_o  out  1  1-cycle pulse on an illegal header.
- frame_cnt_o  out  CNT_WIDTH  good frames (feature-gated).
- err_cnt_o  out  CNT_WIDTH  length errors plus aborts (feature-gated).

Behaviour:
- Reset: state IDLE. All outputs 0. Internal word register, byte index, bytes_left, words_left and abort_pend all 0.
- States:
  - IDLE: s_ready_o=0. Go to HDR when en_i=1.
  - HDR: s_ready_o=1. On a word handshake, L = s_data_i[LEN_WIDTH-1:0].
    - L==0 or L>MAX_FRAME_LEN: len_err_o pulses next cycle; stay in HDR. No payload is consumed; the next word is treated as a header.
    - Otherwise: bytes_left=L, words_left=ceil(L/4); go to DATA_WAIT.
    - If en_i=0 while in HDR: go to IDLE.
  - DATA_WAIT: s_ready_o=1. On handshake, latch the word, idx=0, words_left-1; go to SEND.
  - SEND: m_tvalid_o=1, m_tdata_o = word[8*idx+:8], m_tlast_o = (bytes_left==1), m_tuser_o=0. On a byte handshake: bytes_left-1, idx+1.
    - Last byte of a word (idx==3 with bytes_left>1): s_ready_o = m_tready_i. If s_valid_i is also high, load the next word with idx=0 and stay in SEND, giving zero-bubble throughput. Otherwise go to DATA_WAIT. This combinational ready path is intended.
    - bytes_left==1 accepted: frame_done_o pulses; go to HDR if en_i=1, else IDLE. Unused upper bytes of the final word are discarded.
  - ABORT_TAIL: presents 0x00 with m_tlast_o=1 and m_tuser_o=1. On handshake go to DRAIN if words_left>0, else HDR/IDLE (per en_i).
  - DRAIN: s_ready_o=1, no output. Discard words until words_left==0, then go to HDR/IDLE.
- AXIS rule: tdata/tlast/tuser stay stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
- clr_i handling:
  - In SEND: sets abort_pend. The presented byte is held until accepted.
    - If that byte had tlast=1, the frame completes normally and abort_pend is cleared.
    - Otherwise go to ABORT_TAIL.
  - In DATA_WAIT: go to ABORT_TAIL on the next cycle.
  - In IDLE, HDR, ABORT_TAIL or DRAIN: ignored.
  - clr_i and a word handshake in the same cycle: the word is consumed first, then the abort is applied.
- en_i deassertion never truncates a frame; it takes effect only at a frame boundary.
- Asynchronous reset mid-frame returns to IDLE at once. The downstream MAC sees tvalid drop; the system resets the MAC together with this block.

Optional Feature:
- Macro UDMA_ETH_TX_SEQ_STATS_EN.
- Defined:
  - frame_cnt_o increments on each frame_done_o.
  - err_cnt_o increments on each len_err_o and on each ABORT_TAIL handshake.
  - Both counters wrap at 2^CNT_WIDTH, reset to 0, and clear on en_i rising edge.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Header 0x00000005, words 0x44332211 and 0x000000AA, tready=1 -> bytes 11,22,33,44,AA; tlast only on AA; frame_done_o pulses once; exactly 3 words consumed.
- Header L=8, words back-to-back, tready=1 -> 8 consecutive tvalid cycles with no bubble; s_ready_o high in the cycle of byte 4's handshake.
- Header 0x00000000, then header 0x000005EF (1519) -> two len_err_o pulses, no AXIS output; the following word is taken as a header.
- Header L=12; clr_i after 3 bytes accepted while tready=0 -> 4th byte held, then 0x00 with tlast=1 and tuser=1; 2 remaining words drained; back in HDR; err_cnt_o=1 with the feature enabled.
- en_i dropped on byte 2 of an L=6 frame -> all 6 bytes sent with tlast; state goes to IDLE; s_ready_o=0 afterwards.
- rstn_i pulsed low mid-SEND -> all outputs 0 in the same cycle; after release, the next word is treated as a header.

Source files
------------

// File: rtl/udma_eth_tx_seq.sv
// uDMA 32-bit word stream to 8-bit AXIS TX frame sequencer.
// Optional stats counters: define UDMA_ETH_TX_SEQ_STATS_EN.
module udma_eth_tx_seq #(
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [31:0]          s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [7:0]           m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 m_tuser_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 len_err_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA_WAIT,
        SEND,
        ABORT_TAIL,
        DRAIN
    } state_e;

    localparam logic [LEN_WIDTH:0] MAX_L = (LEN_WIDTH+1)'(MAX_FRAME_LEN);

    state_e               state_q, state_d;
    logic [31:0]          word_q, word_d;
    logic [1:0]           idx_q, idx_d;
    logic [LEN_WIDTH-1:0] bytes_left_q, bytes_left_d;
    logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
    logic                 abort_q, abort_d;
    logic                 len_err_q, len_err_d;
    logic                 done_q, done_d;

    logic [LEN_WIDTH-1:0] hdr_len;
    logic [LEN_WIDTH:0]   hdr_sum;
    logic [LEN_WIDTH-1:0] hdr_words;
    logic                 hdr_ok;
    logic                 last_byte;
    logic                 word_end;
    state_e               post_frame;

    assign hdr_len    = s_data_i[LEN_WIDTH-1:0];
    assign hdr_sum    = {1'b0, hdr_len} + (LEN_WIDTH+1)'(3);
    assign hdr_words  = {1'b0, hdr_sum[LEN_WIDTH:2]};
    assign hdr_ok     = (hdr_len != '0) && ({1'b0, hdr_len} <= MAX_L);
    assign last_byte  = (bytes_left_q == LEN_WIDTH'(1));
    assign word_end   = (idx_q == 2'd3) && !last_byte;
    assign post_frame = en_i ? HDR : IDLE;

    assign busy_o       = (state_q != IDLE) && (state_q != HDR);
    assign frame_done_o = done_q;
    assign len_err_o    = len_err_q;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            bytes_left_q <= '0;
            words_left_q <= '0;
            abort_q      <= 1'b0;
            len_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            bytes_left_q <= bytes_left_d;
            words_left_q <= words_left_d;
            abort_q      <= abort_d;
            len_err_q    <= len_err_d;
            done_q       <= done_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        idx_d        = idx_q;
        bytes_left_d = bytes_left_q;
        words_left_d = words_left_q;
        abort_d      = abort_q;
        len_err_d    = 1'b0;
        done_d       = 1'b0;
        s_ready_o    = 1'b0;
        m_tvalid_o   = 1'b0;
        m_tdata_o    = 8'h00;
        m_tlast_o    = 1'b0;
        m_tuser_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = HDR;
            end
            HDR: begin
                s_ready_o = 1'b1;
                if (s_valid_i && hdr_ok) begin
                    bytes_left_d = hdr_len;
                    words_left_d = hdr_words;
                    state_d      = DATA_WAIT;
                end else if (s_valid_i) begin
                    len_err_d = 1'b1;
                    if (!en_i) state_d = IDLE;
                end else if (!en_i) begin
                    state_d = IDLE;
                end
            end
            DATA_WAIT: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    word_d       = s_data_i;
                    idx_d        = 2'd0;
                    words_left_d = words_left_q - LEN_WIDTH'(1);
                    state_d      = clr_i ? ABORT_TAIL : SEND;
                end else if (clr_i) begin
                    state_d = ABORT_TAIL;
                end
            end
            SEND: begin
                m_tvalid_o = 1'b1;
                m_tdata_o  = word_q[{idx_q, 3'b000} +: 8];
                m_tlast_o  = last_byte;
                if (word_end) s_ready_o = m_tready_i && !abort_q;
                if (m_tready_i) begin
                    bytes_left_d = bytes_left_q - LEN_WIDTH'(1);
                    idx_d        = idx_q + 2'd1;
                    abort_d      = 1'b0;
                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = post_frame;
                    end else if (word_end && s_valid_i && !abort_q) begin
                        word_d       = s_data_i;
                        idx_d        = 2'd0;
                        words_left_d = words_left_q - LEN_WIDTH'(1);
                        if (clr_i) state_d = ABORT_TAIL;
                    end else if (abort_q || clr_i) begin
                        state_d = ABORT_TAIL;
                    end else if (word_end) begin
                        state_d = DATA_WAIT;
                    end
                end else if (clr_i) begin
                    abort_d = 1'b1;
                end
            end
            ABORT_TAIL: begin
                m_tvalid_o = 1'b1;
                m_tlast_o  = 1'b1;
                m_tuser_o  = 1'b1;
                if (m_tready_i) begin
                    state_d = (words_left_q != '0) ? DRAIN : post_frame;
                end
            end
            DRAIN: begin
                s_ready_o = (words_left_q != '0);
                if (words_left_q == '0) begin
                    state_d = post_frame;
                end else if (s_valid_i) begin
                    words_left_d = words_left_q - LEN_WIDTH'(1);
                    if (words_left_q == LEN_WIDTH'(1)) state_d = post_frame;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UDMA_ETH_TX_SEQ_STATS_EN
    logic                 en_q;
    logic                 tail_hs;
    logic [CNT_WIDTH-1:0] frame_cnt_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    assign tail_hs     = (state_q == ABORT_TAIL) && m_tready_i;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

    // Good-frame and error counters, cleared when the block is re-enabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q        <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            en_q <= en_i;
            if (en_i && !en_q) begin
                frame_cnt_q <= '0;
                err_cnt_q   <= '0;
            end else begin
                if (done_q) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
                if (len_err_q || tail_hs) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign frame_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_udma_eth_tx_seq.sv
// Randomized self-checking bench for udma_eth_tx_seq.
// Expected byte streams are built from frame headers and payload words.
module tb_udma_eth_tx_seq;

    localparam int LW = 16;
    localparam int CW = 16;
    localparam int MAXL = 1518;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic          busy;
    logic          frame_done;
    logic          len_err;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;

    udma_eth_tx_seq #(
        .LEN_WIDTH(LW),
        .MAX_FRAME_LEN(MAXL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rstn_i(rst_n),
        .en_i(en),
        .clr_i(clr),
        .s_data_i(s_data),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_tdata_o(m_tdata),
        .m_tvalid_o(m_tvalid),
        .m_tready_i(m_tready),
        .m_tlast_o(m_tlast),
        .m_tuser_o(m_tuser),
        .busy_o(busy),
        .frame_done_o(frame_done),
        .len_err_o(len_err),
        .frame_cnt_o(frame_cnt),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [9:0]  out_q[$];
    logic [31:0] src_q[$];
    int n_done = 0;
    int n_lerr = 0;
    int n_words = 0;
    int stab_err = 0;
    bit hs_w = 0;
    bit pend_chk = 0;
    bit auto_rdy = 1;
    int vpct = 100;
    int rpct = 100;
    logic [9:0] prev_o = '0;

    // Observe handshakes half a cycle before the edge that commits them.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_chk = 0;
            hs_w = 0;
        end else begin
            if (pend_chk && (!m_tvalid ||
                {m_tuser, m_tlast, m_tdata} !== prev_o))
                stab_err++;
            pend_chk = m_tvalid && !m_tready;
            prev_o = {m_tuser, m_tlast, m_tdata};
            if (m_tvalid && m_tready) out_q.push_back(prev_o);
            if (frame_done) n_done++;
            if (len_err) n_lerr++;
            hs_w = s_valid && s_ready;
            if (hs_w) n_words++;
        end
    end

    // Word source and optional random backpressure.
    always @(posedge clk) begin
        #1;
        if (hs_w) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            hs_w = 0;
            s_valid = 0;
        end
        if (src_q.size() == 0) begin
            s_valid = 0;
        end else if (!s_valid && int'($urandom_range(99)) < vpct) begin
            s_valid = 1;
            s_data = src_q[0];
        end
        if (auto_rdy) m_tready = int'($urandom_range(99)) < rpct;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n, input int lim);
        int c = 0;
        while (out_q.size() < n && c < lim) begin
            @(posedge clk);
            c++;
        end
        #2;
    endtask

    task automatic test_reset();
        logic [39:0] v;
        #12;
        v = {s_ready, m_tvalid, m_tlast, m_tuser, m_tdata, busy,
             frame_done, len_err, frame_cnt, err_cnt};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_in: got %h want 0", v);
        end
        @(posedge clk);
        #2 rst_n = 1;
        cyc(3);
        v = {s_ready, m_tvalid, m_tlast, m_tuser, m_tdata, busy,
             frame_done, len_err, frame_cnt, err_cnt};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0", v);
        end
        en = 1;
        cyc(2);
        total++;
        if ({s_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL hdr_state: got %b want 10", {s_ready, busy});
        end
    endtask

    task automatic test_basic();
        logic [7:0] eb[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        int d0 = n_done;
        int w0 = n_words;
        out_q.delete();
        auto_rdy = 1;
        rpct = 100;
        vpct = 100;
        src_q.push_back(32'h0000_0005);
        src_q.push_back(32'h4433_2211);
        src_q.push_back(32'h0000_00AA);
        wait_out(5, 100);
        cyc(5);
        total++;
        if (out_q.size() != 5) begin
            bad++;
            $display("FAIL basic_len: got %0d want 5", out_q.size());
        end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== {1'b0, i == 4, eb[i]}) begin
                bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i,
                         out_q[i], {1'b0, i == 4, eb[i]});
            end
        end
        total++;
        if (n_done - d0 != 1 || n_words - w0 != 3) begin
            bad++;
            $display("FAIL basic_cnt: got done=%0d words=%0d want 1 3",
                     n_done - d0, n_words - w0);
        end
    endtask

    task automatic test_back_to_back();
        bit tv[60];
        bit sr[60];
        int first = -1;
        int run = 0;
        int ntv = 0;
        logic [31:0] w0 = $urandom();
        logic [31:0] w1 = $urandom();
        logic [31:0] tmp;
        out_q.delete();
        src_q.push_back(32'd8);
        src_q.push_back(w0);
        src_q.push_back(w1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            tv[c] = m_tvalid && m_tready;
            sr[c] = s_ready;
        end
        for (int c = 0; c < 60; c++) begin
            if (tv[c]) ntv++;
            if (tv[c] && first < 0) first = c;
        end
        if (first >= 0)
            while (first + run < 60 && tv[first + run]) run++;
        total++;
        if (ntv != 8 || run != 8) begin
            bad++;
            $display("FAIL b2b_run: got total=%0d run=%0d want 8 8", ntv, run);
        end
        total++;
        if (first < 0 || !sr[first + 3]) begin
            bad++;
            $display("FAIL b2b_ready4: got first=%0d want s_ready=1", first);
        end
        total++;
        if (out_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_len: got %0d want 8", out_q.size());
        end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            tmp = (i < 4) ? w0 : w1;
            total++;
            if (out_q[i] !== {1'b0, i == 7, tmp[8*(i%4) +: 8]}) begin
                bad++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, out_q[i],
                         {1'b0, i == 7, tmp[8*(i%4) +: 8]});
            end
        end
    endtask

    task automatic test_len_err();
        int l0 = n_lerr;
        int w0 = n_words;
        out_q.delete();
        src_q.push_back(32'h0000_0000);
        src_q.push_back(32'h0000_05EF);
        src_q.push_back(32'h0000_0001);
        src_q.push_back(32'hDDCC_BBAA);
        wait_out(1, 100);
        cyc(6);
        total++;
        if (n_lerr - l0 != 2) begin
            bad++;
            $display("FAIL lenerr_pulses: got %0d want 2", n_lerr - l0);
        end
        total++;
        if (out_q.size() != 1 || out_q[0] !== 10'h1AA) begin
            bad++;
            $display("FAIL lenerr_out: got n=%0d want one 1aa", out_q.size());
        end
        total++;
        if (n_words - w0 != 4) begin
            bad++;
            $display("FAIL lenerr_words: got %0d want 4", n_words - w0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] w0 = $urandom();
        logic [CW-1:0] e0 = err_cnt;
        int w_0 = n_words;
        logic [10:0] v;
        out_q.delete();
        auto_rdy = 0;
        m_tready = 1;
        src_q.push_back(32'd12);
        src_q.push_back(w0);
        src_q.push_back($urandom());
        src_q.push_back($urandom());
        wait_out(3, 100);
        m_tready = 0;
        clr = 1;
        cyc(1);
        clr = 0;
        cyc(3);
        v = {m_tvalid, m_tlast, m_tuser, m_tdata};
        total++;
        if (v !== {3'b100, w0[31:24]}) begin
            bad++;
            $display("FAIL abort_hold: got %h want %h", v, {3'b100, w0[31:24]});
        end
        m_tready = 1;
        cyc(12);
        total++;
        if (out_q.size() != 5) begin
            bad++;
            $display("FAIL abort_len: got %0d want 5", out_q.size());
        end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== {2'b00, w0[8*i +: 8]}) begin
                bad++;
                $display("FAIL abort_byte%0d: got %h want %h", i, out_q[i],
                         {2'b00, w0[8*i +: 8]});
            end
        end
        total++;
        if (out_q.size() < 5 || out_q[4] !== 10'h300) begin
            bad++;
            $display("FAIL abort_tail: got n=%0d want tail 300", out_q.size());
        end
        total++;
        if (n_words - w_0 != 4 || busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_drain: got words=%0d busy=%b rdy=%b want 4 0 1",
                     n_words - w_0, busy, s_ready);
        end
`ifdef UDMA_ETH_TX_SEQ_STATS_EN
        total++;
        if (err_cnt !== e0 + CW'(1)) begin
            bad++;
            $display("FAIL abort_errcnt: got %0d want %0d", err_cnt, e0 + CW'(1));
        end
`else
        total++;
        if (err_cnt !== '0 || e0 !== '0) begin
            bad++;
            $display("FAIL abort_errcnt: got %0d want 0", err_cnt);
        end
`endif
        auto_rdy = 1;
    endtask

    task automatic test_en_drop();
        logic [31:0] w0 = $urandom();
        logic [31:0] w1 = $urandom();
        logic [31:0] tmp;
        int d0 = n_done;
        int wc = n_words;
        int l0 = n_lerr;
        out_q.delete();
        rpct = 100;
        src_q.push_back(32'd6);
        src_q.push_back(w0);
        src_q.push_back(w1);
        src_q.push_back(32'd0);
        wait_out(2, 100);
        en = 0;
        wait_out(6, 100);
        cyc(5);
        total++;
        if (out_q.size() != 6) begin
            bad++;
            $display("FAIL endrop_len: got %0d want 6", out_q.size());
        end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            tmp = (i < 4) ? w0 : w1;
            total++;
            if (out_q[i] !== {1'b0, i == 5, tmp[8*(i%4) +: 8]}) begin
                bad++;
                $display("FAIL endrop_byte%0d: got %h want %h", i, out_q[i],
                         {1'b0, i == 5, tmp[8*(i%4) +: 8]});
            end
        end
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || n_words - wc != 3 ||
            n_done - d0 != 1) begin
            bad++;
            $display("FAIL endrop_idle: got busy=%b rdy=%b words=%0d done=%0d want 0 0 3 1",
                     busy, s_ready, n_words - wc, n_done - d0);
        end
        en = 1;
        cyc(6);
        total++;
        if (n_lerr - l0 != 1 || n_words - wc != 4) begin
            bad++;
            $display("FAIL endrop_resume: got lerr=%0d words=%0d want 1 4",
                     n_lerr - l0, n_words - wc);
        end
    endtask

    task automatic test_random();
        logic [9:0]  exp_q[$];
        logic [31:0] w;
        logic [31:0] hdr;
        int L;
        int nv = 0;
        int ni = 0;
        int nw = 0;
        int d0 = n_done;
        int l0 = n_lerr;
        int wc = n_words;
        int c = 0;
        int nerr = 0;
        logic [CW-1:0] f0 = frame_cnt;
        logic [CW-1:0] e0 = err_cnt;
        out_q.delete();
        stab_err = 0;
        vpct = 60;
        rpct = 65;
        for (int f = 0; f < 34; f++) begin
            if (f == 0) L = 1;
            else if (f == 1) L = 4;
            else if (f == 2) L = MAXL;
            else if (f == 3) L = MAXL + 1;
            else if ($urandom_range(9) == 0)
                L = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(65535, MAXL + 1));
            else L = int'($urandom_range(40, 1));
            hdr = ($urandom() & 32'hFFFF_0000) | 32'(L);
            src_q.push_back(hdr);
            nw++;
            if (L == 0 || L > MAXL) begin
                ni++;
            end else begin
                nv++;
                for (int k = 0; k < (L + 3) / 4; k++) begin
                    w = $urandom();
                    src_q.push_back(w);
                    nw++;
                    for (int b = 0; b < 4; b++)
                        if (4 * k + b < L)
                            exp_q.push_back({1'b0, 4 * k + b == L - 1, w[8*b +: 8]});
                end
            end
        end
        while ((out_q.size() < exp_q.size() || src_q.size() > 0) && c < 30000) begin
            @(posedge clk);
            c++;
        end
        cyc(10);
        total++;
        if (out_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_len: got %0d want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] !== exp_q[i]) nerr++;
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL rand_bytes: got %0d wrong bytes want 0", nerr);
        end
        total++;
        if (n_done - d0 != nv || n_lerr - l0 != ni || n_words - wc != nw) begin
            bad++;
            $display("FAIL rand_cnt: got done=%0d lerr=%0d words=%0d want %0d %0d %0d",
                     n_done - d0, n_lerr - l0, n_words - wc, nv, ni, nw);
        end
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL rand_stable: got %0d violations want 0", stab_err);
        end
`ifdef UDMA_ETH_TX_SEQ_STATS_EN
        total++;
        if (frame_cnt !== f0 + CW'(nv) || err_cnt !== e0 + CW'(ni)) begin
            bad++;
            $display("FAIL rand_stats: got %0d %0d want %0d %0d", frame_cnt,
                     err_cnt, f0 + CW'(nv), e0 + CW'(ni));
        end
`else
        total++;
        if (frame_cnt !== '0 || err_cnt !== '0 || f0 !== e0) begin
            bad++;
            $display("FAIL rand_stats: got %0d %0d want 0 0", frame_cnt, err_cnt);
        end
`endif
        vpct = 100;
        rpct = 100;
    endtask

    task automatic test_async_reset();
        logic [39:0] v;
        auto_rdy = 0;
        m_tready = 0;
        out_q.delete();
        src_q.push_back(32'd8);
        src_q.push_back($urandom());
        src_q.push_back($urandom());
        cyc(6);
        total++;
        if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: got tvalid=%b busy=%b want 1 1", m_tvalid, busy);
        end
        src_q.delete();
        s_valid = 0;
        rst_n = 0;
        #1;
        v = {s_ready, m_tvalid, m_tlast, m_tuser, m_tdata, busy,
             frame_done, len_err, frame_cnt, err_cnt};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL arst_out: got %h want 0", v);
        end
        cyc(2);
        rst_n = 1;
        m_tready = 1;
        auto_rdy = 1;
        cyc(3);
        out_q.delete();
        src_q.push_back(32'd2);
        src_q.push_back(32'h0000_BBAA);
        wait_out(2, 100);
        cyc(3);
        total++;
        if (out_q.size() != 2 || out_q[0] !== 10'h0AA || out_q[1] !== 10'h1BB) begin
            bad++;
            $display("FAIL arst_after: got n=%0d want 0aa 1bb", out_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_len_err();
        test_abort();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
